// File: rtl/sram_cmd_ctrl.sv
// sram_cmd_ctrl: byte-serial command decoder and sole master of the on-chip
// SRAM macro. Turns strobed command/data bytes into single-cycle read/write
// strobes, returns read data, and runs a hardware FILL over every address.
module sram_cmd_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cmd_byte,
  input  logic              cmd_strobe,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_FILL  = 3'd4
  } state_t;

  localparam logic [1:0]        LAT_CNT  = 2'(READ_LAT);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              state_r, state_s;
  logic                strobe_q_r;
  logic                fill_op_r, fill_op_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [DATA_W-1:0]   din_r, din_s;
  logic                en_r, en_s;
  logic                we_r, we_s;
  logic                busy_r, busy_s;
  logic [DATA_W-1:0]   rd_data_r, rd_data_s;
  logic                rd_valid_r, rd_valid_s;
  logic                err_r, err_s;
  logic [1:0]          cnt_r, cnt_s;
  logic                edge_s;
  logic                unused_ok_s;

  // Only a rising strobe delivers a byte; strobe_q resets high so a strobe
  // held through reset release is not mistaken for a new byte.
  assign edge_s      = cmd_strobe & ~strobe_q_r;
  assign unused_ok_s = ^cmd_byte;

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_s    = state_r;
    fill_op_s  = fill_op_r;
    addr_s     = addr_r;
    din_s      = din_r;
    en_s       = 1'b0;
    we_s       = 1'b0;
    busy_s     = busy_r;
    rd_data_s  = rd_data_r;
    rd_valid_s = rd_valid_r;
    err_s      = err_r;
    cnt_s      = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (edge_s) begin
          rd_valid_s = 1'b0;
          case (cmd_byte[7:6])
            2'b00: err_s = 1'b0;
            2'b01: begin
              state_s = ST_RD;
              addr_s  = cmd_byte[ADDR_W-1:0];
              en_s    = 1'b1;
              busy_s  = 1'b1;
              cnt_s   = 2'd0;
            end
            2'b10: begin
              state_s   = ST_WDATA;
              addr_s    = cmd_byte[ADDR_W-1:0];
              fill_op_s = 1'b0;
            end
            2'b11: begin
              state_s   = ST_WDATA;
              addr_s    = cmd_byte[ADDR_W-1:0];
              fill_op_s = 1'b1;
            end
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (edge_s) begin
          din_s  = cmd_byte;
          en_s   = 1'b1;
          we_s   = 1'b1;
          busy_s = 1'b1;
          if (fill_op_r) begin
            state_s = ST_FILL;
            addr_s  = {ADDR_W{1'b0}};
          end else begin
            state_s = ST_WR;
          end
        end else begin
          state_s = ST_WDATA;
        end
      end
      ST_RD: begin
        // Enable was a one-cycle pulse; now wait out the macro latency.
        if (cnt_r == LAT_CNT) begin
          rd_data_s  = sram_dout;
          rd_valid_s = 1'b1;
          busy_s     = 1'b0;
          state_s    = ST_IDLE;
        end else begin
          cnt_s = cnt_r + 2'd1;
        end
      end
      ST_WR: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      ST_FILL: begin
        if (addr_r == ADDR_MAX) begin
          addr_s  = {ADDR_W{1'b0}};
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          addr_s = addr_r + ADDR_ONE;
          en_s   = 1'b1;
          we_s   = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
    // A byte arriving while busy is discarded; only the error flag records it.
    if (edge_s && busy_r) begin
      err_s = 1'b1;
    end else begin
      err_s = err_s;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      strobe_q_r <= 1'b1;
      fill_op_r  <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      din_r      <= {DATA_W{1'b0}};
      en_r       <= 1'b0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
      err_r      <= 1'b0;
      cnt_r      <= 2'd0;
    end else begin
      state_r    <= state_s;
      strobe_q_r <= cmd_strobe;
      fill_op_r  <= fill_op_s;
      addr_r     <= addr_s;
      din_r      <= din_s;
      en_r       <= en_s;
      we_r       <= we_s;
      busy_r     <= busy_s;
      rd_data_r  <= rd_data_s;
      rd_valid_r <= rd_valid_s;
      err_r      <= err_s;
      cnt_r      <= cnt_s;
    end
  end

  assign busy      = busy_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign err       = err_r;
  assign sram_en   = en_r;
  assign sram_we   = we_r;
  assign sram_addr = addr_r;
  assign sram_din  = din_r;

endmodule

// File: tb/tb_sram_cmd_ctrl.sv
// Directed bench for sram_cmd_ctrl: one instance with READ_LAT=1 and one with
// READ_LAT=3, each attached to a small behavioural SRAM model.
module tb_sram_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_strobe = 1'b0;
  logic       cmd_strobe3 = 1'b0;

  logic       busy, rd_valid, err, sram_en, sram_we;
  logic [7:0] rd_data, sram_din, sram_dout;
  logic [4:0] sram_addr;
  logic       busy3, rd_valid3, err3, sram_en3, sram_we3;
  logic [7:0] rd_data3, sram_din3, sram_dout3;
  logic [4:0] sram_addr3;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_cmd_ctrl #(.ADDR_W(5), .DATA_W(8), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_byte(cmd_byte), .cmd_strobe(cmd_strobe),
    .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .err(err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  sram_cmd_ctrl #(.ADDR_W(5), .DATA_W(8), .READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_byte(cmd_byte), .cmd_strobe(cmd_strobe3),
    .busy(busy3), .rd_data(rd_data3), .rd_valid(rd_valid3), .err(err3),
    .sram_en(sram_en3), .sram_we(sram_we3), .sram_addr(sram_addr3),
    .sram_din(sram_din3), .sram_dout(sram_dout3)
  );

  // SRAM model, latency 1
  logic [7:0] mem1 [0:31];
  logic [7:0] q1 = 8'h00;
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem1[sram_addr] <= sram_din;
      else q1 <= mem1[sram_addr];
    end
  end
  assign sram_dout = q1;

  // SRAM model, latency 3
  logic [7:0] mem3 [0:31];
  logic [7:0] p0 = 8'h00, p1 = 8'h00, p2 = 8'h00;
  always @(posedge clk) begin
    if (sram_en3) begin
      if (sram_we3) mem3[sram_addr3] <= sram_din3;
      else p0 <= mem3[sram_addr3];
    end
    p1 <= p0;
    p2 <= p1;
  end
  assign sram_dout3 = p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    cmd_byte = b;
    cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
  endtask

  task automatic send3(input logic [7:0] b);
    cmd_byte = b;
    cmd_strobe3 = 1'b1;
    tick();
    cmd_strobe3 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_byte = 8'h45;
    cmd_strobe = 1'b1;
    cmd_strobe3 = 1'b1;
    tick();
    tick();
    n_checks++; if ({busy, rd_valid, err, sram_en, sram_we} !== 5'b00000) begin n_fail++; $display("FAIL reset_flags: got %b expected %b", {busy, rd_valid, err, sram_en, sram_we}, 5'b00000); end
    n_checks++; if ({rd_data, sram_din, sram_addr} !== 21'h0) begin n_fail++; $display("FAIL reset_buses: got %h expected %h", {rd_data, sram_din, sram_addr}, 21'h0); end
    n_checks++; if ({busy3, rd_valid3, err3, sram_en3, sram_we3, rd_data3, sram_addr3} !== 18'h0) begin n_fail++; $display("FAIL reset_dut3: got %h expected %h", {busy3, rd_valid3, err3, sram_en3, sram_we3, rd_data3, sram_addr3}, 18'h0); end
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++; if ({busy, sram_en, err} !== 3'b000) begin n_fail++; $display("FAIL reset_held_strobe: got %b expected %b", {busy, sram_en, err}, 3'b000); end
    n_checks++; if ({busy3, sram_en3} !== 2'b00) begin n_fail++; $display("FAIL reset_held_strobe3: got %b expected %b", {busy3, sram_en3}, 2'b00); end
    cmd_strobe = 1'b0;
    cmd_strobe3 = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    send(8'h85);
    n_checks++; if ({busy, sram_en} !== 2'b00) begin n_fail++; $display("FAIL wr_cmd_idle: got %b expected %b", {busy, sram_en}, 2'b00); end
    tick();
    send(8'hA5);
    n_checks++; if ({sram_en, sram_we, busy, sram_addr, sram_din} !== {3'b111, 5'd5, 8'hA5}) begin n_fail++; $display("FAIL wr_strobe: got %h expected %h", {sram_en, sram_we, busy, sram_addr, sram_din}, {3'b111, 5'd5, 8'hA5}); end
    tick();
    n_checks++; if ({sram_en, sram_we, busy} !== 3'b000) begin n_fail++; $display("FAIL wr_end: got %b expected %b", {sram_en, sram_we, busy}, 3'b000); end
    send(8'h45);
    n_checks++; if ({sram_en, sram_we, busy, rd_valid, sram_addr} !== {4'b1010, 5'd5}) begin n_fail++; $display("FAIL rd_strobe: got %h expected %h", {sram_en, sram_we, busy, rd_valid, sram_addr}, {4'b1010, 5'd5}); end
    tick();
    n_checks++; if ({sram_en, busy, rd_valid} !== 3'b010) begin n_fail++; $display("FAIL rd_wait: got %b expected %b", {sram_en, busy, rd_valid}, 3'b010); end
    tick();
    n_checks++; if ({busy, rd_valid, rd_data} !== {2'b01, 8'hA5}) begin n_fail++; $display("FAIL rd_capture: got %h expected %h", {busy, rd_valid, rd_data}, {2'b01, 8'hA5}); end
  endtask

  task automatic test_fill();
    int busy_cycles;
    send(8'hC0);
    tick();
    send(8'h3C);
    busy_cycles = busy ? 1 : 0;
    n_checks++; if ({sram_en, sram_we, busy, sram_addr, sram_din} !== {3'b111, 5'd0, 8'h3C}) begin n_fail++; $display("FAIL fill_start: got %h expected %h", {sram_en, sram_we, busy, sram_addr, sram_din}, {3'b111, 5'd0, 8'h3C}); end
    for (int i = 1; i < 32; i++) begin
      if (i == 10) begin cmd_byte = 8'h45; cmd_strobe = 1'b1; end
      if (i == 11) cmd_strobe = 1'b0;
      if (i == 31) begin cmd_byte = 8'h00; cmd_strobe = 1'b1; end
      tick();
      if (busy) busy_cycles++;
      n_checks++; if ({sram_en, sram_we, sram_addr, sram_din} !== {2'b11, 5'(i), 8'h3C}) begin n_fail++; $display("FAIL fill_step%0d: got %h expected %h", i, {sram_en, sram_we, sram_addr, sram_din}, {2'b11, 5'(i), 8'h3C}); end
    end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL fill_err_set: got %b expected %b", err, 1'b1); end
    tick();
    cmd_strobe = 1'b0;
    n_checks++; if ({sram_en, sram_we, busy, sram_addr} !== 8'h00) begin n_fail++; $display("FAIL fill_end: got %h expected %h", {sram_en, sram_we, busy, sram_addr}, 8'h00); end
    n_checks++; if (busy_cycles !== 32) begin n_fail++; $display("FAIL fill_busy_len: got %0d expected %0d", busy_cycles, 32); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL fill_final_edge_drop: got %b expected %b", err, 1'b1); end
    tick();
    send(8'h00);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL nop_clears_err: got %b expected %b", err, 1'b0); end
    tick();
    send(8'h40);
    tick();
    tick();
    n_checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL fill_rd_addr0: got %h expected %h", {rd_valid, rd_data}, {1'b1, 8'h3C}); end
    send(8'h5F);
    tick();
    tick();
    n_checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL fill_rd_addr31: got %h expected %h", {rd_valid, rd_data}, {1'b1, 8'h3C}); end
  endtask

  task automatic test_back_to_back();
    send(8'h45);
    tick();
    cmd_byte = 8'h00;
    cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
    n_checks++; if ({err, busy, rd_valid, rd_data} !== {3'b101, 8'h3C}) begin n_fail++; $display("FAIL b2b_last_busy_drop: got %h expected %h", {err, busy, rd_valid, rd_data}, {3'b101, 8'h3C}); end
    tick();
    send(8'h00);
    n_checks++; if ({err, rd_valid} !== 2'b00) begin n_fail++; $display("FAIL b2b_nop_accept: got %b expected %b", {err, rd_valid}, 2'b00); end
    tick();
    send(8'h86);
    tick();
    send(8'h99);
    tick();
    send(8'h46);
    n_checks++; if ({busy, sram_en, sram_we, err, sram_addr} !== {4'b1100, 5'd6}) begin n_fail++; $display("FAIL b2b_first_free_edge: got %h expected %h", {busy, sram_en, sram_we, err, sram_addr}, {4'b1100, 5'd6}); end
    tick();
    tick();
    n_checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h99}) begin n_fail++; $display("FAIL b2b_read_back: got %h expected %h", {rd_valid, rd_data}, {1'b1, 8'h99}); end
  endtask

  task automatic test_read_lat3();
    send3(8'h87);
    tick();
    send3(8'h5A);
    tick();
    send3(8'h47);
    n_checks++; if ({busy3, sram_en3, rd_valid3} !== 3'b110) begin n_fail++; $display("FAIL lat3_cmd: got %b expected %b", {busy3, sram_en3, rd_valid3}, 3'b110); end
    for (int i = 1; i < 4; i++) begin
      tick();
      n_checks++; if ({busy3, sram_en3, rd_valid3} !== 3'b100) begin n_fail++; $display("FAIL lat3_wait%0d: got %b expected %b", i, {busy3, sram_en3, rd_valid3}, 3'b100); end
    end
    tick();
    n_checks++; if ({busy3, rd_valid3, rd_data3} !== {2'b01, 8'h5A}) begin n_fail++; $display("FAIL lat3_capture: got %h expected %h", {busy3, rd_valid3, rd_data3}, {2'b01, 8'h5A}); end
    tick();
    n_checks++; if ({rd_valid3, rd_data3} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL lat3_hold: got %h expected %h", {rd_valid3, rd_data3}, {1'b1, 8'h5A}); end
    send3(8'h00);
    n_checks++; if ({rd_valid3, rd_data3} !== {1'b0, 8'h5A}) begin n_fail++; $display("FAIL lat3_valid_clear: got %h expected %h", {rd_valid3, rd_data3}, {1'b0, 8'h5A}); end
  endtask

  task automatic test_reset_mid_fill();
    tick();
    send(8'hC0);
    tick();
    send(8'h77);
    for (int i = 1; i <= 10; i++) tick();
    n_checks++; if ({sram_en, sram_addr} !== {1'b1, 5'd10}) begin n_fail++; $display("FAIL rst_fill_pre: got %h expected %h", {sram_en, sram_addr}, {1'b1, 5'd10}); end
    rst_n = 1'b0;
    tick();
    n_checks++; if ({busy, rd_valid, err, sram_en, sram_we, rd_data, sram_din, sram_addr} !== 26'h0) begin n_fail++; $display("FAIL rst_fill_zero: got %h expected %h", {busy, rd_valid, err, sram_en, sram_we, rd_data, sram_din, sram_addr}, 26'h0); end
    rst_n = 1'b1;
    tick();
    n_checks++; if ({busy, sram_en} !== 2'b00) begin n_fail++; $display("FAIL rst_fill_idle: got %b expected %b", {busy, sram_en}, 2'b00); end
    send(8'h45);
    tick();
    tick();
    n_checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h77}) begin n_fail++; $display("FAIL rst_fill_rd5: got %h expected %h", {rd_valid, rd_data}, {1'b1, 8'h77}); end
    send(8'h54);
    tick();
    tick();
    n_checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL rst_fill_rd20: got %h expected %h", {rd_valid, rd_data}, {1'b1, 8'h3C}); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fill();
    test_back_to_back();
    test_read_lat3();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
